// File: rtl/camera_param_latch.sv
// Latches a frame-coherent copy of the HPS PIO camera parameters: a sample is accepted only
// after it has held steady for STABLE_CYCLES, and it is committed only while the pipeline is idle.
module camera_param_latch #(
    parameter int NUM_WORDS     = 18,
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_RETRIES   = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [32*NUM_WORDS-1:0]   param_in,
    input  logic                      frame_start,
    input  logic                      pipe_idle,
    input  logic                      clear_status,
    output logic [32*NUM_WORDS-1:0]   param_out,
    output logic                      param_valid,
    output logic                      changed,
    output logic                      busy,
    output logic [15:0]               commit_count,
    output logic                      tear_error,
    output logic                      frame_overrun
);
    localparam int W = 32 * NUM_WORDS;
    localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] RETRY_LAST  = 4'(MAX_RETRIES - 1);

    typedef enum logic [1:0] {IDLE, VERIFY, COMMIT} state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   sample_reg;
    logic [3:0]     stable_cnt_reg;
    logic [3:0]     retry_cnt_reg;
    logic [NUM_WORDS-1:0] word_match;
    logic           all_match;
    logic           load_sample, stable_inc, retry_inc, retry_clr, do_commit, set_tear;

    // Word-wise compare keeps each equality a short 32-bit reduction before the final AND.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_match
            assign word_match[gi] = (param_in[gi*32 +: 32] == sample_reg[gi*32 +: 32]);
        end
    endgenerate
    assign all_match = &word_match;
    assign busy      = (state_reg != IDLE);

    always_comb begin
        state_next  = state_reg;
        load_sample = 1'b0;
        stable_inc  = 1'b0;
        retry_inc   = 1'b0;
        retry_clr   = 1'b0;
        do_commit   = 1'b0;
        set_tear    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    load_sample = 1'b1;
                    retry_clr   = 1'b1;
                    state_next  = VERIFY;
                end
            end
            VERIFY: begin
                if (all_match) begin
                    stable_inc = 1'b1;
                    if (stable_cnt_reg == STABLE_LAST) begin
                        state_next = COMMIT;
                    end
                end else begin
                    // A mismatch restarts the stability window on the fresh value.
                    load_sample = 1'b1;
                    retry_inc   = 1'b1;
                    if (retry_cnt_reg == RETRY_LAST) begin
                        set_tear   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            COMMIT: begin
                if (pipe_idle) begin
                    do_commit  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            sample_reg     <= '0;
            stable_cnt_reg <= '0;
            retry_cnt_reg  <= '0;
            param_out      <= '0;
            param_valid    <= 1'b0;
            changed        <= 1'b0;
            commit_count   <= '0;
            tear_error     <= 1'b0;
            frame_overrun  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_sample) begin
                sample_reg     <= param_in;
                stable_cnt_reg <= '0;
            end else if (stable_inc) begin
                stable_cnt_reg <= stable_cnt_reg + 4'd1;
            end
            if (retry_clr) begin
                retry_cnt_reg <= '0;
            end else if (retry_inc) begin
                retry_cnt_reg <= retry_cnt_reg + 4'd1;
            end
            param_valid <= do_commit;
            changed     <= do_commit && (sample_reg != param_out);
            if (do_commit) begin
                param_out    <= sample_reg;
                commit_count <= commit_count + 16'd1;
            end
            // Sticky flags: a set in the same cycle as a clear wins.
            tear_error    <= set_tear | (tear_error & ~clear_status);
            frame_overrun <= (frame_start & busy) | (frame_overrun & ~clear_status);
        end
    end
endmodule

// File: tb/tb_camera_param_latch.sv
// Randomized scoreboard bench for camera_param_latch: a run-length model of each update attempt
// predicts commit time, data and flags; a negedge monitor checks every param_valid against the queue.
module tb_camera_param_latch;
    localparam int NW    = 18;
    localparam int W     = 32 * NW;
    localparam int S     = 4;
    localparam int MR    = 15;
    localparam int DEPTH = 160;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  param_in = '0;
    logic          frame_start = 1'b0;
    logic          pipe_idle = 1'b0;
    logic          clear_status = 1'b0;
    logic [W-1:0]  param_out;
    logic          param_valid, changed, busy, tear_error, frame_overrun;
    logic [15:0]   commit_count;

    camera_param_latch #(.NUM_WORDS(NW), .STABLE_CYCLES(S), .MAX_RETRIES(MR)) dut (
        .clk(clk), .reset(reset), .param_in(param_in), .frame_start(frame_start),
        .pipe_idle(pipe_idle), .clear_status(clear_status), .param_out(param_out),
        .param_valid(param_valid), .changed(changed), .busy(busy),
        .commit_count(commit_count), .tear_error(tear_error), .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         chg;
        logic [15:0]  cnt;
        int           cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            cyc = 0;
    int            checks = 0;
    int            passed = 0;
    logic [W-1:0]  seq[DEPTH];
    logic [W-1:0]  model_out = '0;
    logic [15:0]   model_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic chk_bus(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every param_valid must match the oldest expectation, including its cycle.
    logic [W-1:0] last_out = '0;
    logic         rst_prev = 1'b1;
    always @(negedge clk) begin
        if (param_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_param_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_cycle", cyc, e.cyc);
                chk_bus("param_out", param_out, e.data);
                chk("changed", {31'd0, changed}, {31'd0, e.chg});
                chk("commit_count", {16'd0, commit_count}, {16'd0, e.cnt});
            end
        end else begin
            if (changed) chk("changed_without_valid", 32'd1, 32'd0);
            if (!rst_prev) chk_bus("param_out_stable", param_out, last_out);
        end
        last_out = param_out;
        rst_prev = reset;
    end

    task automatic gen_seq(input logic [W-1:0] base, input int pct, input int chg_until);
        logic [W-1:0] tmp;
        int w;
        seq[0] = base;
        for (int i = 1; i < DEPTH; i++) begin
            tmp = seq[i-1];
            if (i < chg_until && $urandom_range(99) < pct) begin
                w = $urandom_range(NW - 1);
                tmp[w*32 +: 32] = tmp[w*32 +: 32] ^ ($urandom() | 32'd1);
            end
            seq[i] = tmp;
        end
    endtask

    // One update attempt: frame_start in local cycle 0, param_in = seq[i] in local cycle i.
    task automatic run_txn(input int idle_from, input int extra_fs, input bit clr_with_extra);
        int s, chg_n, vd, endc, extra, t0;
        bit tear, ovr;
        exp_t e;
        s = 0; chg_n = 0; vd = -1; endc = 0; tear = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (seq[i] !== seq[i-1]) begin
                chg_n++;
                s = i;
                if (chg_n == MR) begin
                    tear = 1'b1;
                    endc = i;
                    break;
                end
            end else if (i - s == S) begin
                vd = i;
                break;
            end
        end
        if (!tear) endc = (idle_from > vd + 1) ? idle_from : vd + 1;
        extra = extra_fs;
        if (extra_fs == -2) extra = ($urandom_range(1) == 1) ? $urandom_range(endc, 1) : -1;
        ovr = (extra >= 1 && extra <= endc);
        t0 = 0;
        for (int i = 0; i <= endc + 2; i++) begin
            @(posedge clk); #1;
            if (i == 0) t0 = cyc;
            if (i == 0 && !tear) begin
                e.data = seq[s];
                e.chg  = (seq[s] !== model_out);
                e.cnt  = model_cnt + 16'd1;
                e.cyc  = t0 + endc + 1;
                exp_q.push_back(e);
                model_out = seq[s];
                model_cnt = model_cnt + 16'd1;
            end
            param_in     = seq[i];
            pipe_idle    = (i >= idle_from);
            frame_start  = (i == 0) || (i == extra);
            clear_status = (i == endc + 1) || (clr_with_extra && i == extra);
            @(negedge clk);
            if (i >= 1 && i <= endc + 1)
                chk("busy", {31'd0, busy}, {31'd0, (i <= endc)});
            if (i == endc + 1) begin
                chk("tear_error", {31'd0, tear_error}, {31'd0, tear});
                chk("frame_overrun", {31'd0, frame_overrun}, {31'd0, ovr});
                chk_bus("param_out_after_txn", param_out, model_out);
                chk("count_after_txn", {16'd0, commit_count}, {16'd0, model_cnt});
            end
            if (i == endc + 2) begin
                chk("tear_cleared", {31'd0, tear_error}, 32'd0);
                chk("overrun_cleared", {31'd0, frame_overrun}, 32'd0);
            end
        end
        @(posedge clk); #1;
        frame_start = 1'b0; clear_status = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int k = 0; k < NW; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        logic [W-1:0] v;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_bus("reset_param_out", param_out, '0);
        chk("reset_flags", {26'd0, param_valid, changed, busy, tear_error, frame_overrun, 1'b0}, 32'd0);
        chk("reset_count", {16'd0, commit_count}, 32'd0);

        // Basic commit of eye_x = 1.0 with stable data.
        v = rand_vec();
        v[31:0] = 32'h0001_0000;
        gen_seq(v, 0, 0);
        run_txn(0, -1, 1'b0);
        // Tear recovery: eye_y flips once at local cycle 2.
        v = rand_vec();
        gen_seq(v, 0, 0);
        for (int i = 2; i < DEPTH; i++) seq[i][63:32] = ~v[63:32];
        run_txn(0, -1, 1'b0);
        // Retry exhaustion: data changes every cycle for 20 cycles.
        gen_seq(rand_vec(), 100, 21);
        run_txn(0, -1, 1'b0);
        // Pipeline hold: pipe_idle low for 50 cycles while the sample waits in COMMIT.
        gen_seq(rand_vec(), 0, 0);
        run_txn(55, -1, 1'b0);
        // Overrun with identical data re-committed; second request is ignored.
        gen_seq(model_out, 0, 0);
        run_txn(0, 2, 1'b0);
        // Overrun set and clear in the same cycle: set must win.
        gen_seq(rand_vec(), 0, 0);
        run_txn(0, 3, 1'b1);

        // Reset in the middle of verification discards the sample.
        @(posedge clk); #1;
        param_in = rand_vec(); pipe_idle = 1'b1; frame_start = 1'b1;
        @(posedge clk); #1; frame_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk_bus("midreset_param_out", param_out, '0);
        chk("midreset_flags", {26'd0, param_valid, changed, busy, tear_error, frame_overrun, 1'b0}, 32'd0);
        chk("midreset_count", {16'd0, commit_count}, 32'd0);
        model_out = '0;
        model_cnt = '0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("midreset_no_commit", {31'd0, busy}, 32'd0);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(3))
                0: gen_seq(model_out, 0, 0);
                1: gen_seq(rand_vec(), 100, 25);
                default: gen_seq(rand_vec(), $urandom_range(40, 5), 40);
            endcase
            run_txn($urandom_range(40), -2, 1'($urandom_range(1)));
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pending_expectations", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passed, checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/camera_param_latch.md
CAMERA_PARAM_LATCH -- requirements
Module: camera_param_latch

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 18, meaning the number of 32-bit HPS PIO parameter words.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4 (legal 1..15), meaning the consecutive matching samples required before commit.
REQ-003 SHALL have parameter MAX_RETRIES, default 15 (legal 1..15), meaning the mismatch restarts allowed per update attempt.
REQ-004 SHALL have port clk, input, 1 bit: the single clock (raymarcher/VGA domain).
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port param_in, input, 32*NUM_WORDS bits: raw PIO exports, word0 in LSBs; order eye_x, eye_y, eye_z, lookat_1_1..lookat_3_3 (row-major), red_shift, green_shift, blue_shift, fog_shift, color_enables, repetition_pow.
REQ-007 SHALL have port frame_start, input, 1 bit: one-cycle pulse at start of vertical blank, requesting an update.
REQ-008 SHALL have port pipe_idle, input, 1 bit: high when the raymarch pipeline holds no in-flight pixels.
REQ-009 SHALL have port clear_status, input, 1 bit: pulse that clears the sticky flags.
REQ-010 SHALL have port param_out, output, 32*NUM_WORDS bits: committed, frame-coherent parameter set, same packing as param_in.
REQ-011 SHALL have port param_valid, output, 1 bit: one-cycle pulse in the first cycle a new param_out is visible.
REQ-012 SHALL have port changed, output, 1 bit: one-cycle pulse coincident with param_valid when the new param_out differs from the previous one.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port commit_count, output, 16 bits: number of commits, wrapping modulo 2^16.
REQ-015 SHALL have port tear_error, output, 1 bit: sticky flag, set when an update is aborted on retry exhaustion.
REQ-016 SHALL have port frame_overrun, output, 1 bit: sticky flag, set when frame_start arrives while busy.

Function
REQ-017 SHALL implement the states IDLE, VERIFY and COMMIT, all registered.
REQ-018 In IDLE, on frame_start: sample_reg<=param_in, stable_cnt<=0, retry_cnt<=0, next state VERIFY.
REQ-019 In VERIFY on param_in==sample_reg (all bits): stable_cnt++; on the match where stable_cnt==STABLE_CYCLES-1, next state COMMIT.
REQ-020 In VERIFY on mismatch: sample_reg<=param_in, stable_cnt<=0, retry_cnt++; if retry_cnt==MAX_RETRIES-1 before the increment, go to IDLE, set tear_error, and leave param_out unchanged.
REQ-021 In COMMIT with pipe_idle low: hold state indefinitely, with no resampling and no timeout.
REQ-022 In COMMIT with pipe_idle high: param_out<=sample_reg, param_valid<=1, changed<=(sample_reg!=param_out), commit_count++, next state IDLE.
REQ-023 Latency: with stable input and pipe_idle high, frame_start in cycle t SHALL produce param_out/param_valid in cycle t+STABLE_CYCLES+2.
REQ-024 frame_start while busy SHALL be ignored for sequencing and SHALL set frame_overrun; no request is queued.
REQ-025 clear_status SHALL clear both sticky flags; when a set and a clear occur in the same cycle, the set wins.
REQ-026 param_out SHALL change only in the cycle after COMMIT and never mid-frame otherwise.
REQ-027 param_valid and changed SHALL be low in every cycle other than the one specified in REQ-022.
REQ-028 commit_count SHALL wrap from 0xFFFF to 0x0000 without a flag.

Reset
REQ-029 reset SHALL force the state to IDLE and clear param_out, sample_reg, stable_cnt, retry_cnt, commit_count, param_valid, changed, tear_error and frame_overrun to 0, with busy reading 0.
REQ-030 reset SHALL take priority over all other inputs, including mid-VERIFY and mid-COMMIT.
REQ-031 After reset, a partially verified sample SHALL be discarded and SHALL never be committed.

Verification
REQ-032 Basic commit: param_in constant with eye_x=0x00010000, pipe_idle=1, frame_start at t -> param_out word0=0x00010000 and param_valid=1 at t+6, changed=1, commit_count=1, busy low at t+6.
REQ-033 Tear recovery: eye_y toggles at t+2 then holds -> one retry, commit at t+8, tear_error=0.
REQ-034 Retry exhaustion: param_in changes every cycle for 20 cycles after frame_start -> busy drops after 15 mismatches, tear_error=1, param_out unchanged, no param_valid.
REQ-035 Pipeline hold: pipe_idle=0 for 50 cycles -> param_out unchanged and busy=1 until pipe_idle rises; commit occurs the next cycle.
REQ-036 Overrun and no change: frame_start at t and t+2 with identical data committed twice -> frame_overrun=1, second commit has changed=0; clear_status -> frame_overrun=0.
REQ-037 Reset mid-VERIFY at t+3 -> all outputs 0 at t+4, no commit follows without a new frame_start.
